// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: receive side of the 640x480@60 VGA link. Recovers the pixel
// position of each Hsync/Vsync/RGB sample, checks sync edges against nominal
// timing, and reports lock once LOCK_FRAMES clean frames have been seen.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   hsync_n, vsync_n  active-low syncs as driven to the connector
//   rgb_i             {R,G,B} 4 bits each
//   x_o, y_o          recovered column/line of the previous clock's sample
//   de_o, rgb_o       visible-pixel valid and registered pixel (0 when !de_o)
//   locked_o          timing locked
//   frame_start_o     one-cycle pulse at x=0,y=0 while locked
//   sync_err_o        one-cycle pulse on a timing violation while checking
module vga_rx_decoder #(
   parameter int unsigned H_VISIBLE   = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_PW        = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_VISIBLE   = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_PW        = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync_n,
   input  logic        vsync_n,
   input  logic [11:0] rgb_i,
   output logic [9:0]  x_o,
   output logic [9:0]  y_o,
   output logic        de_o,
   output logic [11:0] rgb_o,
   output logic        locked_o,
   output logic        frame_start_o,
   output logic        sync_err_o
);

   localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FP + H_PW + H_BP - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FP + V_PW + V_BP - 1);
   localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FP + H_PW);
   localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_PW);
   localparam logic [11:0] TO_LAST  = 12'(2 * (H_VISIBLE + H_FP + H_PW + H_BP) - 1);
   localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

   state_e      state;
   logic [3:0]  good_cnt;
   logic [11:0] timeout;
   logic        hs_q;
   logic        vs_q;

   logic [9:0]  px;
   logic [9:0]  py;
   logic [9:0]  nx;
   logic [9:0]  ny;
   logic        hs_fall;
   logic        hs_rise;
   logic        vs_fall;
   logic        vs_rise;
   logic        violation;
   logic        err_now;
   logic        lock_now;
   logic        locked_next;
   logic        de_next;
   logic        fs_next;
   logic [3:0]  good_inc;

   always_comb begin
      px       = (x_o == H_LAST) ? 10'd0 : x_o + 10'd1;
      py       = y_o;
      if (px == 10'd0) begin
         py = (y_o == V_LAST) ? 10'd0 : y_o + 10'd1;
      end
      hs_fall  = ~hsync_n & hs_q;
      hs_rise  = hsync_n & ~hs_q;
      vs_fall  = ~vsync_n & vs_q;
      vs_rise  = vsync_n & ~vs_q;
      nx       = hs_fall ? HS_START : px;
      ny       = vs_fall ? VS_START : py;
      // Timeout fires once, on the 2*H_TOTAL-th cycle without an hsync fall.
      violation = (hs_fall & (px != HS_START)) |
                  (hs_rise & (px != HS_END)) |
                  (vs_fall & ((py != VS_START) | (px != 10'd0))) |
                  (vs_rise & (py != VS_END)) |
                  (~hs_fall & (timeout == TO_LAST));
      err_now     = (state != StSearch) & violation;
      good_inc    = good_cnt + 4'd1;
      lock_now    = (state == StCheck) & vs_fall & ~violation & (good_inc == LOCK_CNT);
      // Outputs follow the state being entered, so de_o never outlives locked_o.
      locked_next = ((state == StLocked) & ~err_now) | lock_now;
      de_next     = locked_next & (nx < H_VIS) & (ny < V_VIS);
      fs_next     = locked_next & (nx == 10'd0) & (ny == 10'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= StSearch;
         good_cnt      <= '0;
         timeout       <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         x_o           <= '0;
         y_o           <= '0;
         de_o          <= 1'b0;
         rgb_o         <= '0;
         locked_o      <= 1'b0;
         frame_start_o <= 1'b0;
         sync_err_o    <= 1'b0;
      end else begin
         hs_q          <= hsync_n;
         vs_q          <= vsync_n;
         x_o           <= nx;
         y_o           <= ny;
         de_o          <= de_next;
         rgb_o         <= de_next ? rgb_i : 12'h000;
         locked_o      <= locked_next;
         frame_start_o <= fs_next;
         sync_err_o    <= err_now;
         if (hs_fall) begin
            timeout <= '0;
         end else if (timeout != 12'hfff) begin
            timeout <= timeout + 12'd1;
         end
         case (state)
            StSearch: begin
               if (vs_fall) begin
                  state    <= StCheck;
                  good_cnt <= '0;
               end
            end
            StCheck: begin
               if (violation) begin
                  state    <= StSearch;
                  good_cnt <= '0;
               end else if (vs_fall) begin
                  good_cnt <= good_inc;
                  if (lock_now) begin
                     state <= StLocked;
                  end
               end
            end
            StLocked: begin
               if (violation) begin
                  state    <= StSearch;
                  good_cnt <= '0;
               end
            end
            default: state <= StSearch;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a reduced raster (32x19 total) so that
// multi-frame lock sequences stay short. A small timing generator drives the
// syncs; per-cycle monitors accumulate counts that are checked at each step.
module tb_vga_rx_decoder;

   localparam int HV = 16, HFP = 4, HPW = 8, HBP = 4;
   localparam int VV = 12, VFP = 2, VPW = 2, VBP = 3;
   localparam int HT = 32, VT = 19;
   localparam int HS_START = 20, HS_END = 28, VS_START = 14, VS_END = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsync_n;
   logic        vsync_n;
   logic [11:0] rgb_i;
   logic [9:0]  x_o;
   logic [9:0]  y_o;
   logic        de_o;
   logic [11:0] rgb_o;
   logic        locked_o;
   logic        frame_start_o;
   logic        sync_err_o;

   vga_rx_decoder #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_PW(HPW), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_PW(VPW), .V_BP(VBP),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync_n(hsync_n), .vsync_n(vsync_n), .rgb_i(rgb_i),
      .x_o(x_o), .y_o(y_o), .de_o(de_o), .rgb_o(rgb_o), .locked_o(locked_o),
      .frame_start_o(frame_start_o), .sync_err_o(sync_err_o)
   );

   always #20 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Generator state: (h, v) is the position driven on the next tick.
   int  h = 0, v = 0, short_v = -1;
   bit  hs_hold = 0, vs_wide = 0, prev_vs = 1, vfall = 0, meas = 0;
   int  samp_h, samp_v;
   logic [11:0] samp_rgb;

   // Monitors.
   int err_cnt = 0, err_h = -1, err_v = -1;
   int de_cnt, fs_cnt, xy_bad, de_bad, rgb_bad, fs_bad, meas_ticks;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic [3:0] n;
      bit         last, de_exp;
      n       = h[3:0];
      hsync_n = hs_hold ? 1'b1 : !(h >= HS_START && h < HS_END);
      vsync_n = !(v >= VS_START && v < (vs_wide ? VS_END + 1 : VS_END));
      rgb_i   = {n, n, n};
      samp_h  = h;
      samp_v  = v;
      samp_rgb = rgb_i;
      vfall   = prev_vs && !vsync_n;
      prev_vs = vsync_n;
      @(posedge clk);
      #1;
      last = (h == ((v == short_v) ? HT - 2 : HT - 1));
      if (last) begin
         h = 0;
         if (v == short_v) short_v = -1;
         v = (v == VT - 1) ? 0 : v + 1;
      end else begin
         h++;
      end
      if (sync_err_o === 1'b1) begin
         err_cnt++;
         err_h = samp_h;
         err_v = samp_v;
      end
      if (meas) begin
         de_exp = (samp_h < HV) && (samp_v < VV);
         meas_ticks++;
         if (de_o === 1'b1) de_cnt++;
         if (frame_start_o === 1'b1) fs_cnt++;
         if (x_o !== 10'(samp_h) || y_o !== 10'(samp_v)) xy_bad++;
         if (de_o !== de_exp) de_bad++;
         if (rgb_o !== (de_exp ? samp_rgb : 12'h000)) rgb_bad++;
         if (frame_start_o !== (samp_h == 0 && samp_v == 0)) fs_bad++;
      end
   endtask

   task automatic run_to_vfall(output bit ok);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (vfall) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic run_to(input int th, input int tv, output bit ok);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (h == th && v == tv) begin
            ok = 1;
            return;
         end
         tick();
      end
   endtask

   // Lock must appear exactly on the third vsync fall.
   task automatic lock_seq(input string tag);
      bit ok;
      for (int i = 1; i <= 3; i++) begin
         run_to_vfall(ok);
         chk($sformatf("%s_vfall%0d_found", tag, i), ok, 1);
         chk($sformatf("%s_locked_after_vfall%0d", tag, i), locked_o, (i == 3));
      end
   endtask

   initial begin
      bit ok;
      rst_n   = 1'b0;
      hsync_n = 1'b1;
      vsync_n = 1'b1;
      rgb_i   = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", x_o, 0);
      chk("rst_y", y_o, 0);
      chk("rst_de", de_o, 0);
      chk("rst_rgb", rgb_o, 0);
      chk("rst_locked", locked_o, 0);
      chk("rst_fs", frame_start_o, 0);
      chk("rst_err", sync_err_o, 0);
      rst_n = 1'b1;

      // Nominal acquisition from reset, then one fully monitored frame.
      lock_seq("nom");
      chk("nom_no_err", err_cnt, 0);
      de_cnt = 0; fs_cnt = 0; xy_bad = 0; de_bad = 0; rgb_bad = 0; fs_bad = 0;
      meas_ticks = 0;
      meas = 1;
      run_to_vfall(ok);
      meas = 0;
      chk("frame_found", ok, 1);
      chk("frame_ticks", meas_ticks, HT * VT);
      chk("frame_de_cnt", de_cnt, HV * VV);
      chk("frame_fs_cnt", fs_cnt, 1);
      chk("frame_xy_bad", xy_bad, 0);
      chk("frame_de_bad", de_bad, 0);
      chk("frame_rgb_bad", rgb_bad, 0);
      chk("frame_fs_bad", fs_bad, 0);
      chk("frame_no_err", err_cnt, 0);

      // Line 3 shortened by one clock: early hsync fall on line 4.
      short_v = 3;
      run_to(HS_START + 1, 4, ok);
      chk("short_reach", ok, 1);
      chk("short_err_cnt", err_cnt, 1);
      chk("short_err_h", err_h, HS_START);
      chk("short_err_v", err_v, 4);
      chk("short_locked", locked_o, 0);
      chk("short_x_reload", x_o, HS_START);
      lock_seq("short");
      chk("short_single_err", err_cnt, 1);

      // Hsync held high across 70 cycles: timeout 64 cycles after the fall at (20,2).
      err_cnt = 0;
      run_to(HS_END, 2, ok);
      chk("to_reach", ok, 1);
      hs_hold = 1;
      repeat (70) tick();
      hs_hold = 0;
      chk("to_err_cnt", err_cnt, 1);
      chk("to_err_h", err_h, HS_START);
      chk("to_err_v", err_v, 4);
      chk("to_locked", locked_o, 0);
      lock_seq("to");
      chk("to_no_more_err", err_cnt, 1);

      // Vsync three lines wide: error on the late rise at line 17.
      err_cnt = 0;
      vs_wide = 1;
      run_to(1, VS_END + 1, ok);
      vs_wide = 0;
      chk("vs_reach", ok, 1);
      chk("vs_err_cnt", err_cnt, 1);
      chk("vs_err_h", err_h, 0);
      chk("vs_err_v", err_v, VS_END + 1);
      chk("vs_locked", locked_o, 0);
      lock_seq("vs");
      chk("vs_single_err", err_cnt, 1);

      // Asynchronous reset mid-line while locked.
      run_to(8, 5, ok);
      chk("rst_mid_reach", ok, 1);
      chk("rst_mid_pre_de", de_o, 1);
      #5;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_x", x_o, 0);
      chk("rst_mid_y", y_o, 0);
      chk("rst_mid_de", de_o, 0);
      chk("rst_mid_rgb", rgb_o, 0);
      chk("rst_mid_locked", locked_o, 0);
      chk("rst_mid_fs", frame_start_o, 0);
      chk("rst_mid_err", sync_err_o, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      lock_seq("rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
- Receive-side counterpart of our 640x480@60 VGA timing generator; consumes Hsync/Vsync/RGB as driven to the connector.
- Recovers pixel coordinates and data-enable, checks sync timing against nominal parameters and reports lock.
- Used as an on-chip loopback checker and as the front end of the frame-capture path.
- Runs on the same pixel clock as the transmitter (25 MHz, clk/4 of board clock).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_PW, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_PW, 2, vsync pulse width
- V_BP, 33, vertical back porch
- LOCK_FRAMES, 2, consecutive error-free frames required to assert lock

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, reset, asynchronous, active-low
- hsync_n, in, 1, horizontal sync, active-low
- vsync_n, in, 1, vertical sync, active-low
- rgb_i, in, 12, {R,G,B} 4 bits each
- x_o, out, 10, recovered column of the sample taken on the previous clock
- y_o, out, 10, recovered line of that sample
- de_o, out, 1, visible pixel valid
- rgb_o, out, 12, registered pixel; 0 when de_o=0
- locked_o, out, 1, timing locked
- frame_start_o, out, 1, one-cycle pulse at x=0,y=0 while locked
- sync_err_o, out, 1, one-cycle pulse on any timing violation (CHECK/LOCKED only)

Behaviour:
- H_TOTAL=800, V_TOTAL=525. HS_START=H_VISIBLE+H_FP=656, HS_END=752; VS_START=490, VS_END=492.
- Latency: all outputs registered, 1 cycle after the input sample. hs_q/vs_q hold the previous input sample.
- Reset: x_o=0, y_o=0, de_o=0, rgb_o=0, locked_o=0, frame_start_o=0, sync_err_o=0, state=SEARCH, good_cnt=0, timeout=0, hs_q=1, vs_q=1.
- Predicted position px = (x_o==H_TOTAL-1)?0:x_o+1. py = y_o+1 (wrap V_TOTAL-1 -> 0) when px==0, else y_o.
- H alignment: hsync fall (hsync_n=0, hs_q=1) -> x_o<=HS_START. Otherwise x_o<=px. This applies in every state.
- V alignment: vsync fall -> y_o<=VS_START. Otherwise y_o<=py.
- Violations, flagged only in CHECK/LOCKED:
  - hsync fall with px!=HS_START
  - hsync rise with px!=HS_END
  - vsync fall with (py!=VS_START or px!=0)
  - vsync rise with py!=VS_END
  - timeout: no hsync fall for 2*H_TOTAL cycles (12-bit counter, cleared on each hsync fall, saturating).
- States:
  - SEARCH: on vsync fall -> CHECK, good_cnt=0. Timeout is ignored in SEARCH.
  - CHECK: violation -> SEARCH, sync_err_o pulse. Vsync fall with no violation since the last vsync fall -> good_cnt+1; when good_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: violation -> SEARCH, locked_o<=0 on the same edge, sync_err_o pulse.
- Simultaneous violation and vsync fall: the violation wins; good_cnt is not incremented.
- locked_o=1 iff state==LOCKED (registered).
- de_o = locked && next x<H_VISIBLE && next y<V_VISIBLE. rgb_o = de ? rgb_i : 0, registered with the same timing.
- frame_start_o: 1 when locked and the next x=0 and y=0.
- Reset mid-frame: everything returns to reset values at once; relock requires a vsync fall plus LOCK_FRAMES clean frames.

Test Plan:
- Nominal generator stimulus, 4 frames from reset -> locked_o rises on the 3rd vsync fall (1st enters CHECK, next 2 clean); sync_err_o stays 0; x_o/y_o then equal generator h_cnt/v_cnt delayed 1 cycle.
- Locked, rgb_i=h_cnt[3:0] replicated -> de_o high for exactly 640 cycles/line over 480 lines; rgb_o=0 during blanking; frame_start_o exactly once per 420000 cycles.
- Locked, one line shortened to 799 clocks -> sync_err_o single pulse on the early hsync fall; locked_o=0 next cycle; x_o reloads 656; relock after 2 clean frames.
- Locked, hsync held high for 1700 cycles -> timeout pulse at cycle 1600 without hsync fall; state SEARCH; no further err pulses while in SEARCH.
- Vsync pulse 3 lines wide (rise at y=493) -> sync_err_o pulse at the rise; good_cnt cleared; locked_o drops.
- rst_n asserted asynchronously mid-line while locked -> all outputs 0 before the next clk edge; after release, no lock until the 3rd vsync fall.
